sram_access_ctrl: RTL and testbench

- Initiator-side controller that owns the single write/read port of an `sram` instance (DATA_WIDTH x DEPTH, synchronous, 1-cycle read latency).
- Accepts burst commands from a client over valid/ready channels and sequences the SRAM wen/wadr/wdata and ren/radr strobes.
- Captures rdata and returns read beats through a 2-entry response buffer with full backpressure.
- Sits between enclave datapath clients and the on-chip SRAM macro.

---
 rtl/sram_access_ctrl_if.sv | 33 +++
 rtl/sram_access_ctrl.sv | 152 +++++++++++++++
 tb/tb_sram_access_ctrl.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/sram_access_ctrl_if.sv
// sram_access_ctrl_if: client-side command, write-beat and read-beat channels of sram_access_ctrl.
//   cmd_*  : burst command (write flag, start address, length minus one), valid/ready
//   wd_*   : write beats, valid/ready
//   rd_*   : read beats with last-beat flag, valid/ready
//   master : client side, slave : controller side
interface sram_access_ctrl_if #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 10,
    parameter int LEN_WIDTH  = 4
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [LEN_WIDTH-1:0]  cmd_len;
    logic                  wd_valid;
    logic                  wd_ready;
    logic [DATA_WIDTH-1:0] wd_data;
    logic                  rd_valid;
    logic                  rd_ready;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_last;

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_len, wd_valid, wd_data, rd_ready,
        input  cmd_ready, wd_ready, rd_valid, rd_data, rd_last
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len, wd_valid, wd_data, rd_ready,
        output cmd_ready, wd_ready, rd_valid, rd_data, rd_last
    );
endinterface

// File: rtl/sram_access_ctrl.sv
// sram_access_ctrl: burst controller owning the write/read port of a 1-cycle-latency SRAM.
//   clk, rst_n        : clock, asynchronous active-low reset
//   bus (slave)       : cmd / wd / rd channels from the client
//   sram_wen/wadr/wdata, sram_ren/radr, sram_rdata : SRAM port
//   busy              : FSM active or read beats still buffered
//   stat_wr_beats/stat_rd_beats : beat counters when SRAM_CTRL_STATS_EN is defined, else 0
module sram_access_ctrl #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 10,
    parameter int DEPTH      = 1024,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sram_access_ctrl_if.slave     bus,
    output logic                  sram_wen,
    output logic [ADDR_WIDTH-1:0] sram_wadr,
    output logic [DATA_WIDTH-1:0] sram_wdata,
    output logic                  sram_ren,
    output logic [ADDR_WIDTH-1:0] sram_radr,
    input  logic [DATA_WIDTH-1:0] sram_rdata,
    output logic                  busy,
    output logic [31:0]           stat_wr_beats,
    output logic [31:0]           stat_rd_beats
);
    typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;
    state_t                state;
    logic [ADDR_WIDTH-1:0] base;
    logic [LEN_WIDTH-1:0]  beat;
    logic [LEN_WIDTH-1:0]  len;
    logic                  cmd_rdy;
    logic                  wd_rdy;
    logic [ADDR_WIDTH-1:0] adr;
    logic                  wd_fire;
    logic                  pop;
    logic                  credit;
    logic [2:0]            occ;
    logic [DATA_WIDTH-1:0] buf_data [2];
    logic [1:0]            buf_last;
    logic                  rp;
    logic                  wp;
    logic [1:0]            cnt;
    logic                  pend;
    logic                  pend_last;
    logic                  valid;

    // Masking with DEPTH-1 gives the mod-DEPTH wrap since DEPTH is 2**ADDR_WIDTH.
    assign adr        = (base + ADDR_WIDTH'(beat)) & ADDR_WIDTH'(DEPTH - 1);
    assign wd_fire    = bus.wd_valid & wd_rdy;
    assign valid      = cnt != 2'd0;
    assign pop        = valid & bus.rd_ready;
    // Occupancy after this edge including the read in flight; a pop this cycle frees a slot.
    assign occ        = 3'(cnt) + 3'(pend) - 3'(pop);
    assign credit     = occ < 3'd2;
    assign sram_wen   = wd_fire;
    assign sram_wadr  = wd_fire ? adr : '0;
    assign sram_wdata = wd_fire ? bus.wd_data : '0;
    assign sram_ren   = state == READ && credit;
    assign sram_radr  = sram_ren ? adr : '0;
    assign busy       = state != IDLE || valid;
    assign bus.cmd_ready = cmd_rdy;
    assign bus.wd_ready  = wd_rdy;
    assign bus.rd_valid  = valid;
    assign bus.rd_data   = buf_data[rp];
    assign bus.rd_last   = buf_last[rp];

    // Ready outputs are registered alongside the state so they track it exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            base    <= '0;
            beat    <= '0;
            len     <= '0;
            cmd_rdy <= 1'b0;
            wd_rdy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_valid && cmd_rdy) begin
                        base    <= bus.cmd_addr;
                        beat    <= '0;
                        len     <= bus.cmd_len;
                        state   <= bus.cmd_write ? WRITE : READ;
                        cmd_rdy <= 1'b0;
                        wd_rdy  <= bus.cmd_write;
                    end else begin
                        cmd_rdy <= 1'b1;
                    end
                end
                WRITE: begin
                    if (wd_fire) begin
                        beat <= beat + 1'b1;
                        if (beat == len) begin
                            state   <= IDLE;
                            cmd_rdy <= 1'b1;
                            wd_rdy  <= 1'b0;
                        end
                    end
                end
                READ: begin
                    if (sram_ren) begin
                        beat <= beat + 1'b1;
                        if (beat == len) state <= DRAIN;
                    end
                end
                default: begin
                    state   <= IDLE;
                    cmd_rdy <= 1'b1;
                end
            endcase
        end
    end

    // Response buffer: rdata is captured the cycle after ren, in issue order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend        <= 1'b0;
            pend_last   <= 1'b0;
            buf_data[0] <= '0;
            buf_data[1] <= '0;
            buf_last    <= '0;
            rp          <= 1'b0;
            wp          <= 1'b0;
            cnt         <= '0;
        end else begin
            pend      <= sram_ren;
            pend_last <= sram_ren && beat == len;
            if (pend) begin
                buf_data[wp] <= sram_rdata;
                buf_last[wp] <= pend_last;
                wp           <= ~wp;
            end
            if (pop) rp <= ~rp;
            cnt <= cnt + 2'(pend) - 2'(pop);
        end
    end

`ifdef SRAM_CTRL_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_wr_beats <= '0;
            stat_rd_beats <= '0;
        end else begin
            if (sram_wen && !(&stat_wr_beats)) stat_wr_beats <= stat_wr_beats + 1'b1;
            if (pop && !(&stat_rd_beats)) stat_rd_beats <= stat_rd_beats + 1'b1;
        end
    end
`else
    assign stat_wr_beats = '0;
    assign stat_rd_beats = '0;
`endif
endmodule

// File: tb/tb_sram_access_ctrl.sv
// tb_sram_access_ctrl: directed self-checking bench for sram_access_ctrl with a behavioural SRAM.
module tb_sram_access_ctrl;
    localparam int DW = 128;
    localparam int AW = 10;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sram_wen, sram_ren, busy;
    logic [AW-1:0] sram_wadr, sram_radr;
    logic [DW-1:0] sram_wdata, sram_rdata;
    logic [31:0]   stat_wr_beats, stat_rd_beats;
    logic [DW-1:0] mem [1024];
    int            cyc = 0;
    int            hs;
    int            ren_cnt;
    int            errors = 0;
    int            checks = 0;
    logic [31:0]   wr0, rd0;
    logic [AW-1:0] wq[$];
    logic [AW-1:0] rq[$];
    logic [DW-1:0] dq[$];
    logic          lq[$];
    int            cq[$];
    int            wrap_adr[4] = '{1022, 1023, 0, 1};

    always #5 clk = ~clk;

    sram_access_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

    sram_access_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(1024), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .sram_wen(sram_wen), .sram_wadr(sram_wadr), .sram_wdata(sram_wdata),
        .sram_ren(sram_ren), .sram_radr(sram_radr), .sram_rdata(sram_rdata),
        .busy(busy), .stat_wr_beats(stat_wr_beats), .stat_rd_beats(stat_rd_beats)
    );

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (sram_wen) mem[sram_wadr] <= sram_wdata;
        if (sram_ren) sram_rdata <= mem[sram_radr];
    end

    always @(negedge clk) begin
        if (sram_wen) wq.push_back(sram_wadr);
        if (sram_ren) begin
            rq.push_back(sram_radr);
            ren_cnt = ren_cnt + 1;
        end
        if (bus.rd_valid && bus.rd_ready) begin
            dq.push_back(bus.rd_data);
            lq.push_back(bus.rd_last);
            cq.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear();
        wq.delete(); rq.delete(); dq.delete(); lq.delete(); cq.delete();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cmd(input logic w, input logic [AW-1:0] a, input logic [LW-1:0] l);
        bit ok = 1'b0;
        bus.cmd_valid = 1'b1; bus.cmd_write = w; bus.cmd_addr = a; bus.cmd_len = l;
        for (int t = 0; t < 20 && !ok; t++) begin
            @(negedge clk);
            ok = bus.cmd_ready;
            tick();
        end
        bus.cmd_valid = 1'b0;
        hs = cyc;
        chk("cmd_handshake", DW'(ok), 1);
    endtask

    task automatic wr_burst(input logic [AW-1:0] a, input int n, input logic [DW-1:0] d0, input int gap);
        do_cmd(1'b1, a, LW'(n - 1));
        for (int i = 0; i < n; i++) begin
            if (i == gap) begin
                bus.wd_valid = 1'b0;
                tick();
            end
            bus.wd_valid = 1'b1;
            bus.wd_data  = d0 + DW'(i);
            tick();
        end
        bus.wd_valid = 1'b0;
        tick();
    endtask

    task automatic wait_rd(input int n);
        int t = 0;
        while (dq.size() < n && t < 100) begin
            tick();
            t++;
        end
        repeat (3) tick();
        chk("rd_beat_count", DW'(dq.size()), DW'(n));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_addr = '0; bus.cmd_len = '0;
        bus.wd_valid = 0; bus.wd_data = '0; bus.rd_ready = 1'b1;
        ren_cnt = 0;
        repeat (3) tick();
        chk("rst_cmd_ready", DW'(bus.cmd_ready), 0);
        chk("rst_wd_ready", DW'(bus.wd_ready), 0);
        chk("rst_rd_valid", DW'(bus.rd_valid), 0);
        chk("rst_busy", DW'(busy), 0);
        chk("rst_strobes", DW'({sram_wen, sram_ren}), 0);
        @(negedge clk) rst_n = 1'b1;
        tick();
        chk("cmd_ready_after_rst", DW'(bus.cmd_ready), 1);

        // single write then read at 97
        clear();
        wr_burst(10'd97, 1, 137, -1);
        chk("single_wen_count", DW'(wq.size()), 1);
        chk("single_wadr", DW'(wq[0]), 97);
        clear();
        do_cmd(1'b0, 10'd97, 4'd0);
        wait_rd(1);
        chk("single_rd_data", dq[0], 137);
        chk("single_rd_last", DW'(lq[0]), 1);
        chk("single_rd_latency", DW'(cq[0] - hs), 2);
        chk("single_idle_busy", DW'(busy), 0);

        // burst of 4 at 4 with a bubble after beat 1
        wr0 = stat_wr_beats; rd0 = stat_rd_beats;
        clear();
        wr_burst(10'd4, 4, 39, 2);
        chk("burst_wen_count", DW'(wq.size()), 4);
        for (int i = 0; i < 4; i++) chk("burst_wadr", DW'(wq[i]), DW'(4 + i));
        clear();
        do_cmd(1'b0, 10'd4, 4'd3);
        wait_rd(4);
        for (int i = 0; i < 4; i++) begin
            chk("burst_rd_data", dq[i], DW'(39 + i));
            chk("burst_rd_last", DW'(lq[i]), DW'(i == 3));
            chk("burst_rd_cycle", DW'(cq[i] - cq[0]), DW'(i));
        end
`ifdef SRAM_CTRL_STATS_EN
        chk("stat_wr_burst", DW'(stat_wr_beats - wr0), 4);
        chk("stat_rd_burst", DW'(stat_rd_beats - rd0), 4);
`else
        chk("stat_wr_off", DW'(stat_wr_beats), 0);
        chk("stat_rd_off", DW'(stat_rd_beats), 0);
`endif

        // backpressure
        bus.rd_ready = 1'b0;
        clear();
        ren_cnt = 0;
        do_cmd(1'b0, 10'd4, 4'd3);
        repeat (6) begin
            @(negedge clk);
            if (bus.rd_valid) chk("bp_hold_data", bus.rd_data, 39);
        end
        chk("bp_rd_valid", DW'(bus.rd_valid), 1);
        chk("bp_ren_count", DW'(ren_cnt), 2);
        tick();
        bus.rd_ready = 1'b1;
        wait_rd(4);
        for (int i = 0; i < 4; i++) begin
            chk("bp_rd_data", dq[i], DW'(39 + i));
            chk("bp_rd_last", DW'(lq[i]), DW'(i == 3));
        end

        // address wrap
        clear();
        wr_burst(10'd1022, 4, 1, -1);
        for (int i = 0; i < 4; i++) chk("wrap_wadr", DW'(wq[i]), DW'(wrap_adr[i]));
        clear();
        do_cmd(1'b0, 10'd1022, 4'd3);
        wait_rd(4);
        for (int i = 0; i < 4; i++) begin
            chk("wrap_radr", DW'(rq[i]), DW'(wrap_adr[i]));
            chk("wrap_rd_data", dq[i], DW'(1 + i));
        end

        // reset during beat 2 of a len-7 read
        do_cmd(1'b0, 10'd0, 4'd7);
        tick();
        tick();
        chk("mid_ren_active", DW'(sram_ren), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_cmd_ready", DW'(bus.cmd_ready), 0);
        chk("mid_rst_wd_ready", DW'(bus.wd_ready), 0);
        chk("mid_rst_rd_valid", DW'(bus.rd_valid), 0);
        chk("mid_rst_rd_data", bus.rd_data, 0);
        chk("mid_rst_rd_last", DW'(bus.rd_last), 0);
        chk("mid_rst_ren", DW'(sram_ren), 0);
        chk("mid_rst_radr", DW'(sram_radr), 0);
        chk("mid_rst_busy", DW'(busy), 0);
        chk("mid_rst_stats", DW'({stat_wr_beats, stat_rd_beats}), 0);
        ren_cnt = 0;
        repeat (3) tick();
        chk("mid_rst_no_strobes", DW'(ren_cnt), 0);
        @(negedge clk) rst_n = 1'b1;
        tick();
        chk("post_rst_cmd_ready", DW'(bus.cmd_ready), 1);
        chk("post_rst_rd_valid", DW'(bus.rd_valid), 0);
        chk("post_rst_busy", DW'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
